// File: rtl/lan_irq_pkg.sv
// Shared definitions for the LAN/board interrupt controller: register map,
// CONFIG field offsets, FSM encoding and the decoded bus request.
package lan_irq_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_CONFIG  = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_PENDING = 3'd3;
    localparam logic [2:0] ADDR_HOLDOFF = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;

    localparam int EDGE_LSB = 0;
    localparam int INV_LSB  = 16;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_e;

    // Decoded Avalon-MM slave access for one cycle
    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [31:0] wdata;
    } reg_req_t;

endpackage

// File: rtl/lan_irq_sync.sv
// One interrupt input: multi-flop synchronizer plus a previous-act register
// used for rising-edge detection of the polarity-corrected level.
module lan_irq_sync
    import lan_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic inv,
    input  logic rearm,
    input  logic rearm_inv,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   act;
    logic                   act_prev;

    assign level = chain[SYNC_STAGES-1];
    assign act   = level ^ inv;
    assign rise  = act & ~act_prev;

    // Synchronizer chain: raw enters at bit 0, synced level leaves at the top
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chain <= '0;
        else          chain <= {chain[SYNC_STAGES-2:0], raw};
    end

    // Previous act; on a CONFIG write it is loaded with the level seen through
    // the new polarity so a polarity flip does not look like an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   act_prev <= 1'b0;
        else if (rearm) act_prev <= level ^ rearm_inv;
        else            act_prev <= act;
    end

endmodule

// File: rtl/lan_irq_ctrl.sv
// Avalon-MM interrupt controller: per-source sync, polarity, level/edge
// pending, mask, and a holdoff-rate-limited single irq to the CPU.
module lan_irq_ctrl
    import lan_irq_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic [NUM_SRC-1:0] in_port,
    output logic               irq
);

    reg_req_t               req;
    logic                   wr_cfg, wr_mask, wr_pend, wr_hold, wr_stat;

    logic [NUM_SRC-1:0]     edge_q, inv_q, mask_q, pend_q, pend_d;
    logic [NUM_SRC-1:0]     sync_lvl, rise, act;
    logic [HOLDOFF_W-1:0]   hold_q, cnt_q;
    logic [15:0]            acnt_q;
    irq_state_e             state_q, state_d;
    logic                   any_req, load_cnt;
    logic [31:0]            rd_mux;
    logic                   unused_wdata;

    assign req = '{wr:    chipselect & ~write_n,
                   rd:    chipselect &  write_n,
                   addr:  address,
                   wdata: writedata};

    assign wr_cfg  = req.wr && (req.addr == ADDR_CONFIG);
    assign wr_mask = req.wr && (req.addr == ADDR_MASK);
    assign wr_pend = req.wr && (req.addr == ADDR_PENDING);
    assign wr_hold = req.wr && (req.addr == ADDR_HOLDOFF);
    assign wr_stat = req.wr && (req.addr == ADDR_STATUS);

    // Not every writedata bit lands in a register for small NUM_SRC
    assign unused_wdata = ^req.wdata;

    // Per-source synchronizers
    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            lan_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk       (clk),
                .reset_n   (reset_n),
                .raw       (in_port[g]),
                .inv       (inv_q[g]),
                .rearm     (wr_cfg),
                .rearm_inv (req.wdata[INV_LSB+g]),
                .level     (sync_lvl[g]),
                .rise      (rise[g])
            );
        end
    endgenerate

    assign act     = sync_lvl ^ inv_q;
    assign any_req = |(pend_q & mask_q);
    assign irq     = (state_q == ASSERT);

    // Configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= '0;
            inv_q  <= '0;
            mask_q <= '0;
            hold_q <= '0;
        end else begin
            if (wr_cfg) begin
                edge_q <= req.wdata[EDGE_LSB +: NUM_SRC];
                inv_q  <= req.wdata[INV_LSB  +: NUM_SRC];
            end
            if (wr_mask) mask_q <= req.wdata[NUM_SRC-1:0];
            if (wr_hold) hold_q <= req.wdata[HOLDOFF_W-1:0];
        end
    end

    // Pending next value: level bits track act, edge bits latch rises until
    // W1C (a rise beats a clear). A CONFIG write drops every bit that becomes
    // edge-mode, using the new EDGE field so no stale level value survives.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wr_cfg)
                pend_d[i] = req.wdata[EDGE_LSB+i] ? 1'b0 : act[i];
            else if (!edge_q[i])
                pend_d[i] = act[i];
            else if (rise[i])
                pend_d[i] = 1'b1;
            else if (wr_pend && req.wdata[i])
                pend_d[i] = 1'b0;
        end
    end

    // Pending register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; holdoff counter is loaded on ASSERT exit when nonzero
    always_comb begin
        state_d  = state_q;
        load_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ASSERT;
            end
            ASSERT: begin
                if (!any_req) begin
                    if (hold_q != '0) begin
                        state_d  = HOLDOFF;
                        load_cnt = 1'b1;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLDOFF_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holdoff countdown; later HOLDOFF writes only affect the next load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (load_cnt)
            cnt_q <= hold_q;
        else if (state_q == HOLDOFF && cnt_q != '0)
            cnt_q <= cnt_q - HOLDOFF_W'(1);
    end

    // Saturating IDLE->ASSERT counter, cleared by any STATUS write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acnt_q <= '0;
        else if (wr_stat)
            acnt_q <= '0;
        else if (state_q == IDLE && state_d == ASSERT && acnt_q != CNT_MAX)
            acnt_q <= acnt_q + 16'd1;
    end

    // Read mux; unused bits and unmapped addresses read 0
    always_comb begin
        rd_mux = '0;
        case (req.addr)
            ADDR_DATA:    rd_mux[NUM_SRC-1:0] = act;
            ADDR_CONFIG: begin
                rd_mux[EDGE_LSB +: NUM_SRC] = edge_q;
                rd_mux[INV_LSB  +: NUM_SRC] = inv_q;
            end
            ADDR_MASK:    rd_mux[NUM_SRC-1:0]   = mask_q;
            ADDR_PENDING: rd_mux[NUM_SRC-1:0]   = pend_q;
            ADDR_HOLDOFF: rd_mux[HOLDOFF_W-1:0] = hold_q;
            ADDR_STATUS:  rd_mux = {acnt_q, 14'd0, (state_q == HOLDOFF), irq};
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, one cycle after the address is presented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    readdata <= '0;
        else if (req.rd) readdata <= rd_mux;
        else             readdata <= '0;
    end

endmodule
